// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout/retry,
// and releases the core reset only after lock has been stable for a while.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 10,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_count
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W = 8;

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 locked_s;
    logic [RETRY_W-1:0]   retry_d;
    logic                 pll_rst_d;
    logic                 sys_rst_d;
    logic                 ready_d;
    logic                 lock_lost_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Metastability synchronizer for the asynchronous lock indication
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Next-state, counter and retry logic; counter clears on every transition
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        retry_d     = retry_count;
        pll_rst_d   = 1'b0;
        sys_rst_d   = 1'b1;
        ready_d     = 1'b0;
        lock_lost_d = 1'b0;

        case (state_q)
            RESET_PLL: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    if (retry_count != {RETRY_W{1'b1}}) begin
                        retry_d = retry_count + RETRY_W'(1);
                    end
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = RESET_PLL;
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it
        pll_rst_d   = (state_d == RESET_PLL);
        sys_rst_d   = (state_d != RUN);
        ready_d     = (state_d == RUN);
        lock_lost_d = (state_q == RUN) && (state_d == RESET_PLL);
    end

    // State, counter and registered outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_count <= retry_d;
            pll_rst     <= pll_rst_d;
            sys_rst     <= sys_rst_d;
            ready       <= ready_d;
            lock_lost   <= lock_lost_d;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_count;

    int n_checks = 0;
    int n_fail   = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .SYNC_STAGES   (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    always #10 refclk = ~refclk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Count consecutive samples (starting with the current one) with pll_rst == lvl
    task automatic run_len(input logic lvl, output int n, output logic sys_low);
        n = 0;
        sys_low = 1'b0;
        while (pll_rst === lvl && n < 100) begin
            if (sys_rst !== 1'b1) sys_low = 1'b1;
            n++;
            step();
        end
    endtask

    // Steps until sys_rst is observed low; also flags any lock_lost pulse seen
    task automatic wait_sys_low(output int n, output logic ll_seen);
        n = 0;
        ll_seen = 1'b0;
        while (sys_rst !== 1'b0 && n < 60) begin
            step();
            n++;
            if (lock_lost === 1'b1) ll_seen = 1'b1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int   n;
        logic flag;
        logic sys_seen_low;

        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (3) step();
        check("reset_pll_rst",   pll_rst,     1);
        check("reset_sys_rst",   sys_rst,     1);
        check("reset_ready",     ready,       0);
        check("reset_lock_lost", lock_lost,   0);
        check("reset_retry",     retry_count, 0);

        // No lock: 4 high, 20 low, 4 high, 20 low with retries counting
        rst = 1'b0;
        sys_seen_low = 1'b0;
        run_len(1'b1, n, flag); sys_seen_low |= flag;
        check("nolock_rst_len1", n, 4);
        check("nolock_retry0", retry_count, 0);
        run_len(1'b0, n, flag); sys_seen_low |= flag;
        check("nolock_wait_len1", n, 20);
        check("nolock_retry1", retry_count, 1);
        run_len(1'b1, n, flag); sys_seen_low |= flag;
        check("nolock_rst_len2", n, 4);
        run_len(1'b0, n, flag); sys_seen_low |= flag;
        check("nolock_wait_len2", n, 20);
        check("nolock_retry2", retry_count, 2);
        check("nolock_sys_rst_held", sys_seen_low, 0);

        // Clean lock 5 cycles into WAIT_LOCK
        pulse_rst();
        run_len(1'b1, n, flag);
        check("lock_rst_len", n, 4);
        repeat (4) step();
        pll_locked = 1'b1;
        wait_sys_low(n, flag);
        check_win("lock_latency", n, 10, 12);
        check("lock_ready", ready, 1);
        check("lock_no_lock_lost", flag, 0);
        check("lock_retry", retry_count, 0);

        // Lock drops for 3 cycles in STABILIZE, then full re-qualification
        pll_locked = 1'b0;
        pulse_rst();
        run_len(1'b1, n, flag);
        repeat (4) step();
        pll_locked = 1'b1;
        repeat (7) step();
        check("stab_mid_sys_rst", sys_rst, 1);
        pll_locked = 1'b0;
        sys_seen_low = 1'b0;
        repeat (3) begin
            step();
            if (sys_rst !== 1'b1 || ready !== 1'b0) sys_seen_low = 1'b1;
        end
        check("stab_drop_held", sys_seen_low, 0);
        pll_locked = 1'b1;
        wait_sys_low(n, flag);
        check_win("stab_relock_latency", n, 10, 12);
        check("stab_retry", retry_count, 0);

        // Loss of lock in RUN
        repeat (2) step();
        pll_locked = 1'b0;
        step();
        check("run_drop_c1_sys_rst", sys_rst, 0);
        step();
        check("run_drop_c2_sys_rst", sys_rst, 0);
        step();
        check("run_drop_c3_sys_rst",   sys_rst,   1);
        check("run_drop_c3_ready",     ready,     0);
        check("run_drop_c3_lock_lost", lock_lost, 1);
        check("run_drop_c3_pll_rst",   pll_rst,   1);
        pll_locked = 1'b1;
        step();
        check("run_drop_lock_lost_1cyc", lock_lost, 0);
        run_len(1'b1, n, flag);
        check("run_drop_pll_rst_len", n + 1, 4);
        wait_sys_low(n, flag);
        check("run_relock_ready", ready, 1);
        check("run_relock_no_lock_lost", flag, 0);

        // Retry counter saturation
        pll_locked = 1'b0;
        pulse_rst();
        repeat (100 * 24 + 2) step();
        check("sat_retry_100", retry_count, 100);
        repeat (155 * 24) step();
        check("sat_retry_255", retry_count, 255);
        repeat (45 * 24) step();
        check("sat_retry_300", retry_count, 255);

        // rst during RUN (after one retry)
        pulse_rst();
        run_len(1'b1, n, flag);
        run_len(1'b0, n, flag);
        check("rst_run_pre_retry", retry_count, 1);
        pll_locked = 1'b1;
        wait_sys_low(n, flag);
        check("rst_run_pre_ready", ready, 1);
        rst = 1'b1;
        step();
        check("rst_run_pll_rst",   pll_rst,     1);
        check("rst_run_sys_rst",   sys_rst,     1);
        check("rst_run_ready",     ready,       0);
        check("rst_run_lock_lost", lock_lost,   0);
        check("rst_run_retry",     retry_count, 0);

        // rst during STABILIZE
        rst = 1'b0;
        repeat (7) step();
        check("rst_stab_pre_pll_rst", pll_rst, 0);
        rst = 1'b1;
        step();
        check("rst_stab_pll_rst", pll_rst,     1);
        check("rst_stab_sys_rst", sys_rst,     1);
        check("rst_stab_ready",   ready,       0);
        check("rst_stab_retry",   retry_count, 0);

        // One-cycle lock glitch during RESET_PLL is ignored
        pll_locked = 1'b0;
        rst = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        pll_locked = 1'b0;
        run_len(1'b1, n, flag);
        check("glitch_rst_len", n + 2, 4);
        run_len(1'b0, n, flag);
        check("glitch_wait_len", n, 20);
        check("glitch_sys_rst_held", flag, 0);
        check("glitch_retry", retry_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controller on the far end of the PLL's rst/locked interface: drives the PLL reset input and consumes its locked output.
- Pulses PLL reset, waits for lock with a timeout and retry, then requires lock to be stable before releasing the core reset.
- Re-sequences whenever lock is lost.
- Runs on the 50 MHz reference clock, between the PLL wrapper and the Orao core reset tree.

Parameters:
- PLL_RST_CYCLES, 10: refclk cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 50000: refclk cycles to wait for lock before retrying (1 ms at 50 MHz; min 2).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before releasing sys_rst (min 1).
- SYNC_STAGES, 2: synchronizer depth for pll_locked (min 2).

Ports:
- refclk, input, 1: 50 MHz reference clock; the only clock.
- rst, input, 1: synchronous active-high reset.
- pll_locked, input, 1: PLL locked; asynchronous to refclk.
- pll_rst, output, 1: reset to the PLL, active high.
- sys_rst, output, 1: reset to the core clock domain logic, active high.
- ready, output, 1: high while in RUN.
- lock_lost, output, 1: one-cycle pulse when lock drops in RUN.
- retry_count, output, 8: lock-timeout retries since rst; saturates at 255.

Behaviour:
- All outputs are registered. rst is sampled on the refclk rising edge only.
- While rst=1:
  - state=RESET_PLL, counter=0, synchronizer flops=0.
  - pll_rst=1, sys_rst=1, ready=0, lock_lost=0, retry_count=0.
- locked_s is pll_locked after SYNC_STAGES flops. FSM decisions use locked_s only.
- Counter width is sized to the largest of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. The counter clears on every state transition.
- RESET_PLL:
  - pll_rst=1, sys_rst=1, ready=0.
  - Stays exactly PLL_RST_CYCLES cycles (first rst=0 edge counts as cycle 1), then goes to WAIT_LOCK.
  - locked_s is ignored here.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - locked_s=1 -> STABILIZE.
  - Otherwise, after LOCK_TIMEOUT cycles -> RESET_PLL and retry_count+1 (saturating at 255).
  - If locked_s rises on the timeout cycle, lock wins: go to STABILIZE, no retry.
- STABILIZE:
  - pll_rst=0, sys_rst=1.
  - locked_s=0 -> WAIT_LOCK with a fresh timeout; no retry increment.
  - After STABLE_CYCLES consecutive cycles of locked_s=1 -> RUN.
- RUN:
  - pll_rst=0, sys_rst=0, ready=1.
  - locked_s=0 -> RESET_PLL. lock_lost=1 for exactly the cycle sys_rst re-asserts; ready=0 on that same cycle.
- retry_count is never cleared except by rst.
- rst asserted mid-sequence, in any state, returns to RESET_PLL on the next edge with all outputs at reset values.
- Latency from a clean lock:
  - sys_rst falls SYNC_STAGES+STABLE_CYCLES+1 cycles after pll_locked is first sampled high (±1 cycle for async sampling).
  - Loss of lock in RUN reaches sys_rst=1 in SYNC_STAGES+1 cycles.
- No combinational path from pll_locked to any output.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, SYNC_STAGES=2):
- Reset release, pll_locked held at 0 -> pll_rst high exactly 4 cycles, low 20, high 4 again; retry_count 0->1->2; sys_rst constantly 1.
- pll_locked rises 5 cycles into WAIT_LOCK and stays high -> sys_rst falls and ready rises 11 cycles (±1) later; lock_lost never pulses; retry_count=0.
- In STABILIZE, pll_locked drops for 3 cycles at stable count 5 -> FSM returns to WAIT_LOCK, retry_count unchanged; after re-lock, a full 8 stable cycles is required before sys_rst=0.
- In RUN, pll_locked drops -> 3 cycles later sys_rst=1, ready=0, lock_lost=1 for one cycle, pll_rst=1 for 4 cycles; with pll_locked restored, the full sequence repeats.
- 300 consecutive timeouts -> retry_count saturates at 255, no wrap.
- rst asserted during RUN and during STABILIZE -> next edge: pll_rst=1, sys_rst=1, ready=0, retry_count=0; a 1-cycle pll_locked glitch during RESET_PLL has no effect.
